// File: rtl/niosii_pio_pkg.sv
// Shared definitions for the Nios II control PIO blocks: register map offsets,
// Avalon bus widths and the output-PIO handshake state type.
package niosii_pio_pkg;

    localparam int unsigned AV_ADDR_W = 3;
    localparam int unsigned AV_DATA_W = 32;

    localparam logic [AV_ADDR_W-1:0] PIO_DATA   = 3'd0;
    localparam logic [AV_ADDR_W-1:0] PIO_STATUS = 3'd1;
    localparam logic [AV_ADDR_W-1:0] PIO_ACKCNT = 3'd2;
    localparam logic [AV_ADDR_W-1:0] PIO_OUTSET = 3'd4;
    localparam logic [AV_ADDR_W-1:0] PIO_OUTCLR = 3'd5;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pio_state_e;

    // Avalon write strobe decode (write_n is active low)
    function automatic logic av_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/niosii_control_pio_out_if.sv
// Avalon-MM slave port plus the fabric-side valid/ack command port of the output PIO.
interface niosii_control_pio_out_if
    import niosii_pio_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);

    logic [AV_ADDR_W-1:0] address;
    logic                 chipselect;
    logic                 write_n;
    logic [AV_DATA_W-1:0] writedata;
    logic [AV_DATA_W-1:0] readdata;
    logic                 waitrequest;

    logic [WIDTH-1:0]     out_port;
    logic                 out_valid;
    logic                 out_ack;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ack,
        output readdata, waitrequest, out_port, out_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ack,
        input  readdata, waitrequest, out_port, out_valid
    );

endinterface

// File: rtl/niosii_control_pio_out.sv
// Avalon-MM output PIO: software-written command word with valid/ack handshake,
// bit set/clear registers and a wrapping ack counter. Define CONTROL_PIO_OUT_READBACK_EN
// to make the DATA register readable at address 0.
module niosii_control_pio_out
    import niosii_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    niosii_control_pio_out_if.slave  pio
);

    pio_state_e           state_q, state_d;
    logic [WIDTH-1:0]     data_q,  data_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [AV_DATA_W-1:0] rdata_q, rdata_d;

    logic wr_c;
    logic data_sel_c;
    logic waitrequest_c;
    logic data_load_c;
    logic unused_wd_c;

    // Only the low WIDTH bits of writedata carry payload
    assign unused_wd_c = ^pio.writedata;

    assign wr_c          = av_write(pio.chipselect, pio.write_n);
    assign data_sel_c    = wr_c & (pio.address == PIO_DATA);
    // A new command stalls only while the previous one is still unacknowledged
    assign waitrequest_c = data_sel_c & valid_q & ~pio.out_ack;
    assign data_load_c   = data_sel_c & ~waitrequest_c;

    // State and data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= WIDTH'(RESET_VAL);
            valid_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Handshake FSM, ack counter and bit set/clear
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (data_load_c) begin
                    data_d  = pio.writedata[WIDTH-1:0];
                    valid_d = 1'b1;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (pio.out_ack) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A write landing on the ack cycle chains straight into the next command
                    if (data_load_c) begin
                        data_d = pio.writedata[WIDTH-1:0];
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
        endcase

        if (wr_c && (pio.address == PIO_OUTSET)) begin
            data_d = data_d | pio.writedata[WIDTH-1:0];
        end
        if (wr_c && (pio.address == PIO_OUTCLR)) begin
            data_d = data_d & ~pio.writedata[WIDTH-1:0];
        end
        if (wr_c && (pio.address == PIO_ACKCNT)) begin
            cnt_d = '0;
        end
    end

    // Read mux, registered every clock regardless of chipselect
    always_comb begin
        rdata_d = '0;
        case (pio.address)
`ifdef CONTROL_PIO_OUT_READBACK_EN
            PIO_DATA:   rdata_d = AV_DATA_W'(data_q);
`else
            PIO_DATA:   rdata_d = '0;
`endif
            PIO_STATUS: rdata_d = {30'b0, waitrequest_c, valid_q};
            PIO_ACKCNT: rdata_d = AV_DATA_W'(cnt_q);
            default:    rdata_d = '0;
        endcase
    end

    assign pio.readdata    = rdata_q;
    assign pio.waitrequest = waitrequest_c;
    assign pio.out_port    = data_q;
    assign pio.out_valid   = valid_q;

endmodule

// File: tb/tb_niosii_control_pio_out.sv
// Self-checking bench for niosii_control_pio_out: directed scenarios plus a randomized
// run against a transaction-level model of the command/ack register file.
module tb_niosii_control_pio_out;

    localparam int unsigned WIDTH = 8;
`ifdef CONTROL_PIO_OUT_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    niosii_control_pio_out_if #(.WIDTH(WIDTH)) pio ();

    niosii_control_pio_out #(
        .WIDTH    (WIDTH),
        .RESET_VAL(32'd0),
        .CNT_W    (16)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .pio  (pio)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pio.address    = 3'd0;
        pio.chipselect = 1'b0;
        pio.write_n    = 1'b1;
        pio.writedata  = 32'd0;
        pio.out_ack    = 1'b0;
    endtask

    task automatic drive_write(input logic [2:0] a, input logic [31:0] d);
        pio.address    = a;
        pio.chipselect = 1'b1;
        pio.write_n    = 1'b0;
        pio.writedata  = d;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
        pio.address    = a;
        pio.chipselect = 1'b1;
        pio.write_n    = 1'b1;
        step();
        v = pio.readdata;
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_dut();
        read_reg(3'd0, v);
        n_total++; if (v !== 32'h0) $display("FAIL reset_data got=%h exp=%h", v, 32'h0); else n_pass++;
        read_reg(3'd1, v);
        n_total++; if (v !== 32'h0) $display("FAIL reset_status got=%h exp=%h", v, 32'h0); else n_pass++;
        read_reg(3'd2, v);
        n_total++; if (v !== 32'h0) $display("FAIL reset_ackcnt got=%h exp=%h", v, 32'h0); else n_pass++;
        n_total++; if (pio.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", pio.out_valid); else n_pass++;
        n_total++; if (pio.waitrequest !== 1'b0) $display("FAIL reset_wreq got=%b exp=0", pio.waitrequest); else n_pass++;
        n_total++; if (pio.out_port !== 8'h00) $display("FAIL reset_port got=%h exp=00", pio.out_port); else n_pass++;
    endtask

    task automatic test_write_idle();
        logic [31:0] v;
        drive_write(3'd0, 32'h0000_00A5);
        #1;
        n_total++; if (pio.waitrequest !== 1'b0) $display("FAIL idle_wreq got=%b exp=0", pio.waitrequest); else n_pass++;
        step();
        idle_inputs();
        n_total++; if (pio.out_port !== 8'hA5) $display("FAIL idle_port got=%h exp=a5", pio.out_port); else n_pass++;
        n_total++; if (pio.out_valid !== 1'b1) $display("FAIL idle_valid got=%b exp=1", pio.out_valid); else n_pass++;
        read_reg(3'd1, v);
        n_total++; if (v !== 32'h1) $display("FAIL idle_status got=%h exp=%h", v, 32'h1); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] v;
        int stalled;
        stalled = 0;
        drive_write(3'd0, 32'h0000_003C);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (pio.waitrequest === 1'b1) stalled++;
            step();
        end
        n_total++; if (stalled !== 4) $display("FAIL stall_cycles got=%0d exp=4", stalled); else n_pass++;
        n_total++; if (pio.out_port !== 8'hA5) $display("FAIL stall_hold_port got=%h exp=a5", pio.out_port); else n_pass++;
        pio.out_ack = 1'b1;
        #1;
        n_total++; if (pio.waitrequest !== 1'b0) $display("FAIL stall_release got=%b exp=0", pio.waitrequest); else n_pass++;
        step();
        idle_inputs();
        n_total++; if (pio.out_port !== 8'h3C) $display("FAIL stall_port got=%h exp=3c", pio.out_port); else n_pass++;
        n_total++; if (pio.out_valid !== 1'b1) $display("FAIL stall_valid got=%b exp=1", pio.out_valid); else n_pass++;
        read_reg(3'd2, v);
        n_total++; if (v !== 32'h1) $display("FAIL stall_ackcnt got=%h exp=%h", v, 32'h1); else n_pass++;
    endtask

    task automatic test_setclr();
        logic [31:0] v;
        pio.out_ack = 1'b1;
        step();
        idle_inputs();
        n_total++; if (pio.out_valid !== 1'b0) $display("FAIL setclr_ack_valid got=%b exp=0", pio.out_valid); else n_pass++;
        drive_write(3'd0, 32'h0000_00A0);
        step();
        drive_write(3'd4, 32'h0000_000F);
        #1;
        n_total++; if (pio.waitrequest !== 1'b0) $display("FAIL setclr_nostall got=%b exp=0", pio.waitrequest); else n_pass++;
        step();
        n_total++; if (pio.out_port !== 8'hAF) $display("FAIL outset_port got=%h exp=af", pio.out_port); else n_pass++;
        n_total++; if (pio.out_valid !== 1'b1) $display("FAIL outset_valid got=%b exp=1", pio.out_valid); else n_pass++;
        drive_write(3'd5, 32'h0000_0005);
        step();
        idle_inputs();
        n_total++; if (pio.out_port !== 8'hAA) $display("FAIL outclr_port got=%h exp=aa", pio.out_port); else n_pass++;
        n_total++; if (pio.out_valid !== 1'b1) $display("FAIL outclr_valid got=%b exp=1", pio.out_valid); else n_pass++;
        read_reg(3'd4, v);
        n_total++; if (v !== 32'h0) $display("FAIL outset_read got=%h exp=0", v); else n_pass++;
        read_reg(3'd2, v);
        n_total++; if (v !== 32'h2) $display("FAIL setclr_ackcnt got=%h exp=2", v); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        reset_dut();
        drive_write(3'd0, 32'h11);
        step();
        // Chained write+ack counts one ack per cycle
        pio.out_ack = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            pio.writedata = 32'(i);
            step();
        end
        idle_inputs();
        read_reg(3'd2, v);
        n_total++; if (v !== 32'h0000_FFFF) $display("FAIL wrap_max got=%h exp=0000ffff", v); else n_pass++;
        drive_write(3'd0, 32'h22);
        pio.out_ack = 1'b1;
        step();
        idle_inputs();
        read_reg(3'd2, v);
        n_total++; if (v !== 32'h0) $display("FAIL wrap_zero got=%h exp=0", v); else n_pass++;
        n_total++; if (pio.out_valid !== 1'b1) $display("FAIL wrap_valid got=%b exp=1", pio.out_valid); else n_pass++;
        drive_write(3'd0, 32'h33);
        pio.out_ack = 1'b1;
        step();
        idle_inputs();
        read_reg(3'd2, v);
        n_total++; if (v !== 32'h1) $display("FAIL wrap_one got=%h exp=1", v); else n_pass++;
        drive_write(3'd2, 32'hDEAD_BEEF);
        pio.out_ack = 1'b1;
        step();
        idle_inputs();
        read_reg(3'd2, v);
        n_total++; if (v !== 32'h0) $display("FAIL clear_vs_ack got=%h exp=0", v); else n_pass++;
        n_total++; if (pio.out_valid !== 1'b0) $display("FAIL clear_ack_valid got=%b exp=0", pio.out_valid); else n_pass++;
    endtask

    task automatic test_reset_pending();
        drive_write(3'd0, 32'h5A);
        step();
        drive_write(3'd0, 32'h77);
        #1;
        n_total++; if (pio.waitrequest !== 1'b1) $display("FAIL rstp_stalled got=%b exp=1", pio.waitrequest); else n_pass++;
        reset = 1'b1;
        step();
        n_total++; if (pio.out_valid !== 1'b0) $display("FAIL rstp_valid got=%b exp=0", pio.out_valid); else n_pass++;
        n_total++; if (pio.waitrequest !== 1'b0) $display("FAIL rstp_wreq got=%b exp=0", pio.waitrequest); else n_pass++;
        n_total++; if (pio.out_port !== 8'h00) $display("FAIL rstp_port got=%h exp=00", pio.out_port); else n_pass++;
        idle_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_readback();
        logic [31:0] v;
        logic [31:0] exp;
        reset_dut();
        drive_write(3'd0, 32'h0000_00A5);
        step();
        idle_inputs();
        exp = READBACK ? 32'hA5 : 32'h0;
        read_reg(3'd0, v);
        n_total++; if (v !== exp) $display("FAIL readback got=%h exp=%h", v, exp); else n_pass++;
    endtask

    // Reference model: the command register, a pending flag and an ack tally
    task automatic test_random();
        logic [7:0]  m_data;
        logic        m_valid;
        int          m_cnt;
        logic [31:0] m_rd;
        logic [2:0]  a;
        logic [31:0] d;
        logic        cs, wn, ack, is_wr, stall, took_ack;
        reset_dut();
        m_data = 8'h00; m_valid = 1'b0; m_cnt = 0; m_rd = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            a   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            d   = $urandom;
            cs  = ($urandom_range(0, 3) != 0);
            wn  = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 3) == 0);
            pio.address = a; pio.chipselect = cs; pio.write_n = wn;
            pio.writedata = d; pio.out_ack = ack;
            is_wr = cs && !wn;
            stall = is_wr && a == 3'd0 && m_valid && !ack;
            #1;
            n_total++; if (pio.waitrequest !== stall) $display("FAIL rnd_wreq cyc=%0d got=%b exp=%b", cyc, pio.waitrequest, stall); else n_pass++;
            if (a == 3'd0)      m_rd = READBACK ? {24'h0, m_data} : 32'h0;
            else if (a == 3'd1) m_rd = {30'h0, stall, m_valid};
            else if (a == 3'd2) m_rd = 32'(m_cnt);
            else                m_rd = 32'h0;
            took_ack = m_valid && ack;
            if (took_ack) m_cnt = (m_cnt + 1) % 65536;
            if (is_wr && a == 3'd2) m_cnt = 0;
            if (is_wr && a == 3'd0 && !stall) begin
                m_data  = d[7:0];
                m_valid = 1'b1;
            end else if (took_ack) begin
                m_valid = 1'b0;
            end
            if (is_wr && a == 3'd4) m_data = m_data | d[7:0];
            if (is_wr && a == 3'd5) m_data = m_data & ~d[7:0];
            step();
            n_total++; if (pio.out_port !== m_data) $display("FAIL rnd_port cyc=%0d got=%h exp=%h", cyc, pio.out_port, m_data); else n_pass++;
            n_total++; if (pio.out_valid !== m_valid) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, pio.out_valid, m_valid); else n_pass++;
            n_total++; if (pio.readdata !== m_rd) $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, pio.readdata, m_rd); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_idle();
        test_stall();
        test_setclr();
        test_reset_pending();
        test_readback();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
